// File: rtl/dec_scan_pkg.sv
// ============================================================================
// Module  : dec_scan_pkg
// Brief   : Shared types and defaults for the dec_scan_n scan decoder.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package dec_scan_pkg;

  typedef enum logic {
    MODE_SCAN   = 1'b0,
    MODE_DIRECT = 1'b1
  } mode_t;

  localparam int DEF_DIV = 100_000;

endpackage

`default_nettype wire

// File: rtl/dec_n.sv
// ============================================================================
// Module  : dec_n
// Brief   : Combinational W-to-2^W one-hot decoder.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module dec_n #(
  parameter int W = 3
) (
  input  logic [W-1:0]        i_sel,
  output logic [(1<<W)-1:0]   o_onehot
);

  genvar gi;
  generate
    for (gi = 0; gi < (1 << W); gi++) begin : g_bit
      assign o_onehot[gi] = (i_sel == W'(gi));
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/dec_scan_n.sv
// ============================================================================
// Module  : dec_scan_n
// Brief   : Registered W-to-2^W decoder with prescaled scan sequencer,
//           direct-select mode, per-output mask and selectable polarity.
//           Build option DEC_SCAN_SKIP_EN: scan skips masked indices.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module dec_scan_n
  import dec_scan_pkg::*;
#(
  parameter int W          = 3,
  parameter int DIV        = DEF_DIV,
  parameter int ACTIVE_LOW = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                mode,
  input  logic [W-1:0]        sel_in,
  input  logic [(1<<W)-1:0]   mask,
  output logic [(1<<W)-1:0]   y,
  output logic [W-1:0]        idx,
  output logic                tick,
  output logic                wrap
);

  localparam int              c_N      = 1 << W;
  localparam int              c_PW     = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [c_N-1:0]  c_Y_IDLE = (ACTIVE_LOW != 0) ? {c_N{1'b1}} : {c_N{1'b0}};

  logic [c_PW-1:0] r_pre;
  logic [W-1:0]    r_idx;
  logic [c_N-1:0]  r_y;
  logic            r_tick;
  logic            r_wrap;

  mode_t           w_mode;
  logic [c_PW-1:0] w_pre_nxt;
  logic [W-1:0]    w_idx_nxt;
  logic            w_tick_nxt;
  logic            w_wrap_nxt;
  logic [W-1:0]    w_adv_idx;
  logic            w_adv_wrap;
  logic [c_N-1:0]  w_dec;
  logic [c_N-1:0]  w_y_hi;
  logic [c_N-1:0]  w_y_nxt;
`ifdef DEC_SCAN_SKIP_EN
  logic [W:0]      w_sum;
`endif

  assign w_mode = mode_t'(mode);

  always_comb begin
    w_pre_nxt  = r_pre;
    w_idx_nxt  = r_idx;
    w_tick_nxt = 1'b0;
    w_wrap_nxt = 1'b0;
    w_adv_idx  = r_idx;
    w_adv_wrap = 1'b0;
`ifdef DEC_SCAN_SKIP_EN
    // Descending search so the nearest unmasked index wins; bit W of the sum flags a wrap.
    w_sum = '0;
    for (int k = c_N; k >= 1; k--) begin
      w_sum = {1'b0, r_idx} + (W+1)'(k);
      if (mask[w_sum[W-1:0]]) begin
        w_adv_idx  = w_sum[W-1:0];
        w_adv_wrap = w_sum[W];
      end
    end
`else
    w_adv_idx  = r_idx + W'(1);
    w_adv_wrap = (r_idx == W'(c_N - 1));
`endif
    if (w_mode == MODE_DIRECT) begin
      w_idx_nxt = sel_in;
      w_pre_nxt = '0;
    end else if (r_pre == c_PW'(DIV - 1)) begin
      w_pre_nxt  = '0;
      w_idx_nxt  = w_adv_idx;
      w_tick_nxt = 1'b1;
      w_wrap_nxt = w_adv_wrap;
    end else begin
      w_pre_nxt = r_pre + c_PW'(1);
    end
  end

  dec_n #(
    .W (W)
  ) u_dec (
    .i_sel    (w_idx_nxt),
    .o_onehot (w_dec)
  );

  assign w_y_hi = w_dec & mask;

  generate
    if (ACTIVE_LOW != 0) begin : g_active_low
      assign w_y_nxt = ~w_y_hi;
    end else begin : g_active_high
      assign w_y_nxt = w_y_hi;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pre  <= '0;
      r_idx  <= '0;
      r_y    <= c_Y_IDLE;
      r_tick <= 1'b0;
      r_wrap <= 1'b0;
    end else if (en) begin
      r_pre  <= w_pre_nxt;
      r_idx  <= w_idx_nxt;
      r_y    <= w_y_nxt;
      r_tick <= w_tick_nxt;
      r_wrap <= w_wrap_nxt;
    end else begin
      r_tick <= 1'b0;
      r_wrap <= 1'b0;
    end
  end

  assign y    = r_y;
  assign idx  = r_idx;
  assign tick = r_tick;
  assign wrap = r_wrap;

endmodule

`default_nettype wire

// File: tb/tb_dec_scan_n.sv
// ============================================================================
// Module  : tb_dec_scan_n
// Brief   : Directed self-checking bench for dec_scan_n (W=3, DIV=4).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dec_scan_n;

  logic       clk;
  logic       rst;
  logic       en;
  logic       mode;
  logic [2:0] sel_in;
  logic [7:0] mask;
  logic [7:0] y;
  logic [2:0] idx;
  logic       tick;
  logic       wrap;
  logic [7:0] al_y;
  logic [2:0] al_idx;
  logic       al_tick;
  logic       al_wrap;

  int n_tests = 0;
  int n_fail  = 0;

  dec_scan_n #(.W(3), .DIV(4), .ACTIVE_LOW(0)) u_dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .sel_in(sel_in), .mask(mask),
    .y(y), .idx(idx), .tick(tick), .wrap(wrap)
  );

  dec_scan_n #(.W(3), .DIV(4), .ACTIVE_LOW(1)) u_dut_al (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .sel_in(sel_in), .mask(mask),
    .y(al_y), .idx(al_idx), .tick(al_tick), .wrap(al_wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; mode = 1'b0; sel_in = 3'd0; mask = 8'hFF;
    step(); step();
    check_eq("rst_y",    32'(y),    32'h00);
    check_eq("rst_idx",  32'(idx),  32'd0);
    check_eq("rst_tick", 32'(tick), 32'd0);
    check_eq("rst_wrap", 32'(wrap), 32'd0);
    check_eq("al_rst_y", 32'(al_y), 32'hFF);

    rst = 1'b0;
    step();
    check_eq("first_y",    32'(y),    32'h01);
    check_eq("first_tick", 32'(tick), 32'd0);
    step(); step();
    check_eq("pre_tick", 32'(tick), 32'd0);
    step();
    check_eq("t1_y",    32'(y),    32'h02);
    check_eq("t1_idx",  32'(idx),  32'd1);
    check_eq("t1_tick", 32'(tick), 32'd1);
    check_eq("t1_wrap", 32'(wrap), 32'd0);

    for (int t = 2; t <= 8; t++) begin
      for (int e = 0; e < 3; e++) begin
        step();
        check_eq("gap_tick", 32'(tick), 32'd0);
      end
      step();
      check_eq("scan_idx",  32'(idx),  32'(t % 8));
      check_eq("scan_y",    32'(y),    32'(1) << (t % 8));
      check_eq("scan_tick", 32'(tick), 32'd1);
      check_eq("scan_wrap", 32'(wrap), (t == 8) ? 32'd1 : 32'd0);
    end

    // en=0 freeze with prescaler at 2
    step(); step();
    en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      check_eq("frz_y",    32'(y),    32'h01);
      check_eq("frz_idx",  32'(idx),  32'd0);
      check_eq("frz_tick", 32'(tick), 32'd0);
    end
    en = 1'b1;
    step();
    check_eq("unfrz_tick0", 32'(tick), 32'd0);
    step();
    check_eq("unfrz_tick1", 32'(tick), 32'd1);
    check_eq("unfrz_idx",   32'(idx),  32'd1);

    mask = 8'hFB;
    step();
    check_eq("mask_y1", 32'(y),   32'h02);
    check_eq("mask_i1", 32'(idx), 32'd1);
    step(); step(); step();
`ifdef DEC_SCAN_SKIP_EN
    check_eq("mask_idx_a", 32'(idx), 32'd3);
    check_eq("mask_y_a",   32'(y),   32'h08);
`else
    check_eq("mask_idx_a", 32'(idx), 32'd2);
    check_eq("mask_y_a",   32'(y),   32'h00);
`endif
    step(); step(); step(); step();
`ifdef DEC_SCAN_SKIP_EN
    check_eq("mask_idx_b", 32'(idx), 32'd4);
    check_eq("mask_y_b",   32'(y),   32'h10);
`else
    check_eq("mask_idx_b", 32'(idx), 32'd3);
    check_eq("mask_y_b",   32'(y),   32'h08);
`endif

    mask = 8'h00;
    step();
    check_eq("mask0_y1", 32'(y), 32'h00);
    step(); step(); step();
    check_eq("mask0_y",    32'(y),    32'h00);
    check_eq("mask0_idx",  32'(idx),  32'd4);
    check_eq("mask0_tick", 32'(tick), 32'd1);
    check_eq("mask0_wrap", 32'(wrap), 32'd0);

    mask = 8'hFF; mode = 1'b1; sel_in = 3'd5;
    step();
    check_eq("dir5_y",    32'(y),    32'h20);
    check_eq("dir5_idx",  32'(idx),  32'd5);
    check_eq("dir5_tick", 32'(tick), 32'd0);
    sel_in = 3'd7;
    step();
    check_eq("dir7_y",   32'(y),   32'h80);
    check_eq("dir7_idx", 32'(idx), 32'd7);
    sel_in = 3'd3;
    step();
    check_eq("dir3_idx", 32'(idx),  32'd3);
    check_eq("al_dir3_y", 32'(al_y), 32'hF7);
    mask = 8'hF7;
    step();
    check_eq("al_masked_y", 32'(al_y), 32'hFF);
    check_eq("masked_y",    32'(y),    32'h00);
    check_eq("masked_idx",  32'(idx),  32'd3);

    mask = 8'hFF; mode = 1'b0;
    for (int e = 0; e < 3; e++) begin
      step();
      check_eq("resume_gap", 32'(tick), 32'd0);
    end
    step();
    check_eq("resume_tick", 32'(tick), 32'd1);
    check_eq("resume_idx",  32'(idx),  32'd4);
    check_eq("resume_y",    32'(y),    32'h10);
    check_eq("resume_wrap", 32'(wrap), 32'd0);

    step(); step();
    rst = 1'b1;
    step();
    check_eq("mrst_y",    32'(y),    32'h00);
    check_eq("mrst_idx",  32'(idx),  32'd0);
    check_eq("mrst_tick", 32'(tick), 32'd0);
    check_eq("mrst_wrap", 32'(wrap), 32'd0);
    check_eq("al_mrst_y", 32'(al_y), 32'hFF);
    rst = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
